// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//
// Owns the single write port of the RV32IM register file. The port is shared
// by the in-order pipeline writeback stage (source A) and the multi-cycle
// divide unit (source B). Source A normally has priority. A starvation counter
// makes sure a waiting divide result is eventually forced through. In that
// case the pipeline sees one cycle of wb_ready = 0 and holds its request.
//
// A per-register busy scoreboard tracks destinations of in-flight divides so
// the hazard unit can stall instructions that depend on them.
//
// Handshake: a transfer on either source happens in a cycle where the source
// drives valid = 1 and sees its ready = 1. A source that is not accepted holds
// its request (valid, rd, data) stable until it is accepted. Ready is a
// combinational function of the current inputs and state.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   wb_valid/wb_rd/wb_data   pipeline writeback request
//   wb_ready                 pipeline write accepted this cycle
//   div_valid/div_rd/div_data divide result request
//   div_ready                divide result accepted this cycle
//   issue_valid/issue_rd     divide issued this cycle (sets busy bit)
//   rs1, rs2                 decode-stage sources for hazard lookup
//   rs1_busy, rs2_busy       source awaits a divide result
//   div_pending              any busy bit set
//   we/rd/write_data         register file write port (commits next edge)
//   dbg_state                arbiter FSM state (0 IDLE, 1 WAIT, 2 FORCE)
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int XLEN         = 32,
    parameter int REGFILE      = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              wb_ready,
    input  logic              div_valid,
    input  logic [ADDR_W-1:0] div_rd,
    input  logic [XLEN-1:0]   div_data,
    output logic              div_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              div_pending,
    output logic              we,
    output logic [ADDR_W-1:0] rd,
    output logic [XLEN-1:0]   write_data,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [REGFILE-1:0] busy_q, busy_d;
    logic               grant_a, grant_b;

    // ------------------------------------------------------------------
    // Grant. Qualified by rst_n so every output is low while reset is
    // asserted, even though the inputs may still be active.
    // ------------------------------------------------------------------
    always_comb begin
        grant_b = rst_n && div_valid && ((state_q == FORCE) || !wb_valid);
        grant_a = rst_n && wb_valid && !grant_b;
    end

    assign wb_ready  = rst_n && !grant_b;
    assign div_ready = grant_b;

    // ------------------------------------------------------------------
    // Write port mux: zero added latency, idle port drives zeros.
    // ------------------------------------------------------------------
    always_comb begin
        we         = 1'b0;
        rd         = '0;
        write_data = '0;
        if (grant_b) begin
            we         = 1'b1;
            rd         = div_rd;
            write_data = div_data;
        end else if (grant_a) begin
            we         = 1'b1;
            rd         = wb_rd;
            write_data = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Starvation FSM: next state and counter.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (div_valid && !grant_b) begin
                    state_d = WAIT;
                    cnt_d   = 4'd1;
                end
            end
            WAIT: begin
                if (grant_b) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    // Saturating: the counter must never wrap back below
                    // the limit and lose the force.
                    cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                    if (cnt_d >= LIMIT) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                // Either the forced grant happened or div_valid dropped
                // (protocol error); both return to IDLE.
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // Busy scoreboard. Clear on accepted divide result, then set on issue,
    // so a same-cycle reissue to the same rd keeps the bit set.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < REGFILE; i++) begin
            if (grant_b && (div_rd == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (issue_valid && (issue_rd != '0) && (issue_rd == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Lookups read the registered bits, so a same-cycle issue is not seen.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        for (int i = 0; i < REGFILE; i++) begin
            if (rs1 == ADDR_W'(i)) begin
                rs1_busy = busy_q[i];
            end
            if (rs2 == ADDR_W'(i)) begin
                rs2_busy = busy_q[i];
            end
        end
    end

    assign div_pending = |busy_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Directed scenarios followed by constrained-random traffic. The reference
// model tracks how many consecutive cycles a divide result has gone
// unserved, plus a plain array of busy flags. Expected register-file commits
// go through an expected queue.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

    localparam int ADDR_W       = 5;
    localparam int XLEN         = 32;
    localparam int REGFILE      = 32;
    localparam int STARVE_LIMIT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              wb_valid, div_valid, issue_valid;
    logic [ADDR_W-1:0] wb_rd, div_rd, issue_rd, rs1, rs2;
    logic [XLEN-1:0]   wb_data, div_data;
    logic              wb_ready, div_ready, rs1_busy, rs2_busy, div_pending, we;
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   write_data;
    logic [1:0]        dbg_state;

    rf_write_arbiter #(
        .ADDR_W(ADDR_W), .XLEN(XLEN), .REGFILE(REGFILE), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .div_valid(div_valid), .div_rd(div_rd), .div_data(div_data), .div_ready(div_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .div_pending(div_pending),
        .we(we), .rd(rd), .write_data(write_data), .dbg_state(dbg_state)
    );

    // ---------------- reference model ----------------
    bit   busy_m [REGFILE];
    int   streak;          // consecutive cycles a divide result went unserved
    logic force_m, gb_m, ga_m, last_ga, last_gb;

    // ---------------- scoreboard ----------------
    logic [ADDR_W+XLEN-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        streak = 0;
        for (int i = 0; i < REGFILE; i++) busy_m[i] = 1'b0;
    endtask

    // Evaluate combinational outputs a little after the inputs settle.
    task automatic eval_check();
        logic              exp_we, exp_pend;
        logic [ADDR_W-1:0] exp_rd;
        logic [XLEN-1:0]   exp_data;
        logic [1:0]        exp_state;
        #1;
        if (!rst_n) model_reset();
        force_m  = (streak >= STARVE_LIMIT);
        gb_m     = rst_n && div_valid && (force_m || !wb_valid);
        ga_m     = rst_n && wb_valid && !gb_m;
        exp_we   = ga_m || gb_m;
        exp_rd   = gb_m ? div_rd   : (ga_m ? wb_rd   : '0);
        exp_data = gb_m ? div_data : (ga_m ? wb_data : '0);
        exp_pend = 1'b0;
        for (int i = 0; i < REGFILE; i++) exp_pend |= busy_m[i];
        exp_state = (streak == 0) ? 2'd0 : ((streak >= STARVE_LIMIT) ? 2'd2 : 2'd1);

        chk("we",          we,          exp_we);
        chk("rd",          rd,          exp_rd);
        chk("write_data",  write_data,  exp_data);
        chk("wb_ready",    wb_ready,    rst_n && !gb_m);
        chk("div_ready",   div_ready,   gb_m);
        chk("rs1_busy",    rs1_busy,    busy_m[rs1]);
        chk("rs2_busy",    rs2_busy,    busy_m[rs2]);
        chk("div_pending", div_pending, exp_pend);
        chk("state",       dbg_state,   exp_state);

        if (exp_we) exp_q.push_back({exp_rd, exp_data});
        if (we === 1'b1) begin
            if (exp_q.size() == 0) chk("commit_unexpected", 1, 0);
            else chk("commit", {rd, write_data}, exp_q.pop_front());
        end
    endtask

    // Advance one clock and update the model with the values just committed.
    task automatic advance();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (gb_m) busy_m[div_rd] = 1'b0;
            if (issue_valid && issue_rd != 0) busy_m[issue_rd] = 1'b1;
            if (gb_m || force_m) streak = 0;
            else if (streak > 0 || div_valid) streak = (streak < 15) ? streak + 1 : 15;
        end
        last_ga = ga_m;
        last_gb = gb_m;
        @(negedge clk);
    endtask

    task automatic drive_idle();
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        div_valid = 0; div_rd = 0; div_data = 0;
        issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cur;
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        last_ga = 0; last_gb = 0;
        @(negedge clk);

        // Reset state
        eval_check();
        chk("reset_we", we, 0);
        chk("reset_wb_ready", wb_ready, 0);
        advance();
        rst_n = 1'b1;

        // Pipeline write only
        wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        eval_check();
        chk("wb_only_we", we, 1);
        chk("wb_only_rd", rd, 5);
        chk("wb_only_data", write_data, 32'hDEADBEEF);
        chk("wb_only_div_ready", div_ready, 0);
        advance();

        // Issue a divide to rd 7, then its result on an idle port
        drive_idle();
        issue_valid = 1; issue_rd = 7;
        eval_check();
        advance();
        drive_idle();
        div_valid = 1; div_rd = 7; div_data = 32'h12; rs1 = 7;
        eval_check();
        chk("idle_div_ready", div_ready, 1);
        chk("idle_div_rd", rd, 7);
        chk("idle_busy7_before", rs1_busy, 1);
        advance();
        drive_idle();
        rs1 = 7;
        eval_check();
        chk("idle_busy7_cleared", rs1_busy, 0);
        chk("idle_state", dbg_state, 0);
        advance();

        // Starvation: pipeline busy every cycle, divide to rd 3 waiting
        cur = 10;
        div_valid = 1; div_rd = 3; div_data = 32'h333;
        for (int i = 0; i < 6; i++) begin
            wb_valid = 1; wb_rd = ADDR_W'(cur); wb_data = 32'h1000 + cur;
            eval_check();
            if (i < 4) chk("starve_div_ready", div_ready, 0);
            if (i == 4) begin
                chk("force_wb_ready", wb_ready, 0);
                chk("force_div_ready", div_ready, 1);
                chk("force_rd", rd, 3);
            end
            if (i == 5) begin
                chk("held_commit_we", we, 1);
                chk("held_commit_rd", rd, 14);
            end
            advance();
            if (last_ga) cur++;
            if (last_gb) div_valid = 0;
        end

        // Scoreboard: issue rd 9, lookup same cycle sees pre-issue value
        drive_idle();
        issue_valid = 1; issue_rd = 9; rs1 = 9;
        eval_check();
        chk("same_cycle_lookup", rs1_busy, 0);
        advance();
        drive_idle();
        rs1 = 9;
        eval_check();
        chk("sb_rs1_busy", rs1_busy, 1);
        chk("sb_pending", div_pending, 1);
        advance();
        div_valid = 1; div_rd = 9; div_data = 32'h99;
        eval_check();
        advance();
        drive_idle();
        rs1 = 9;
        eval_check();
        chk("sb_rs1_clear", rs1_busy, 0);
        chk("sb_pending_clear", div_pending, 0);
        advance();

        // Simultaneous set and clear on rd 4
        issue_valid = 1; issue_rd = 4;
        eval_check();
        advance();
        drive_idle();
        div_valid = 1; div_rd = 4; div_data = 32'h44;
        issue_valid = 1; issue_rd = 4;
        eval_check();
        advance();
        drive_idle();
        rs2 = 4;
        eval_check();
        chk("set_wins", rs2_busy, 1);
        advance();
        div_valid = 1; div_rd = 4; div_data = 32'h45;
        eval_check();
        advance();
        drive_idle();
        issue_valid = 1; issue_rd = 0;
        eval_check();
        advance();
        drive_idle();
        eval_check();
        chk("x0_not_busy", div_pending, 0);
        advance();

        // Reset in the middle of WAIT
        issue_valid = 1; issue_rd = 6;
        eval_check();
        advance();
        drive_idle();
        div_valid = 1; div_rd = 6; div_data = 32'h66;
        wb_valid = 1; wb_rd = 1; wb_data = 32'h11;
        eval_check();
        advance();
        wb_rd = 2; wb_data = 32'h22;
        eval_check();
        chk("wait_state", dbg_state, 1);
        advance();
        wb_rd = 3; wb_data = 32'h33;
        #2 rst_n = 1'b0;
        eval_check();
        chk("async_rst_we", we, 0);
        chk("async_rst_wb_ready", wb_ready, 0);
        chk("async_rst_pending", div_pending, 0);
        advance();
        rst_n = 1'b1;
        drive_idle();
        rs1 = 6;
        eval_check();
        chk("post_rst_state", dbg_state, 0);
        chk("post_rst_busy6", rs1_busy, 0);
        advance();

        // Constrained-random traffic; sources hold requests until accepted
        for (int n = 0; n < 400; n++) begin
            if (!wb_valid || last_ga) begin
                wb_valid = ($urandom_range(0, 3) != 0);
                wb_rd    = ADDR_W'($urandom_range(0, REGFILE - 1));
                wb_data  = $urandom;
            end
            if (!div_valid || last_gb) begin
                div_valid = ($urandom_range(0, 4) == 0);
                div_rd    = ADDR_W'($urandom_range(0, REGFILE - 1));
                div_data  = $urandom;
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd    = ADDR_W'($urandom_range(0, REGFILE - 1));
            rs1         = ADDR_W'($urandom_range(0, REGFILE - 1));
            rs2         = ADDR_W'($urandom_range(0, REGFILE - 1));
            last_ga = 0; last_gb = 0;
            eval_check();
            advance();
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
